// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, imem request/response port and a small
// instruction buffer feeding decode. Optional same-cycle response bypass: FETCH_BYPASS_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH      = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   input  logic        trapEn,
   input  logic [31:0] trapVec,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemGnt,
   input  logic        imemRvalid,
   input  logic [31:0] imemRdata,
   output logic [31:0] pcOut,
   output logic [31:0] instOut,
   output logic        instValid
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0] NOP   = 32'h0000_0033;

   logic [31:0]      fetch_pc, fetch_pc_nxt;
   logic [31:0]      resp_pc, resp_pc_nxt;
   logic [OUT_W-1:0] outstanding, outstanding_nxt;
   logic [OUT_W-1:0] discard, discard_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [31:0]      buf_pc   [FIFO_DEPTH];
   logic [31:0]      buf_inst [FIFO_DEPTH];
   logic [31:0]      raw_target, target;
   logic             flush, fire, ret, accept, bypass, push, pop, empty, full;

   // Request credit, redirect target and buffer handshakes
   always_comb begin
      flush      = trapEn | redirect;
      raw_target = trapEn ? trapVec : redirectPc;
      target     = raw_target & ~32'd3;
      empty      = (count == '0);
      full       = (32'(count) == FIFO_DEPTH);
      imemReq    = reset && (32'(outstanding) + 32'(count) < FIFO_DEPTH)
                   && (32'(outstanding) < MAX_OUTSTANDING) && !flush;
      imemAddr   = fetch_pc;
      fire       = imemReq & imemGnt;
      ret        = imemRvalid & (outstanding != '0);
      accept     = imemRvalid & ~flush & (discard == '0);
`ifdef FETCH_BYPASS_EN
      bypass     = accept & empty & ~stall;
`else
      bypass     = 1'b0;
`endif
      push       = accept & ~bypass;
      pop        = ~flush & ~stall & ~empty;
   end

   // Next-state: responses in flight at a redirect become the discard count
   always_comb begin
      fetch_pc_nxt    = fetch_pc;
      resp_pc_nxt     = resp_pc;
      outstanding_nxt = outstanding;
      discard_nxt     = discard;
      count_nxt       = count;
      if (fire) begin
         fetch_pc_nxt = fetch_pc + 32'd4;
      end
      if (fire && !ret) begin
         outstanding_nxt = outstanding + OUT_W'(1);
      end else if (!fire && ret) begin
         outstanding_nxt = outstanding - OUT_W'(1);
      end
      if (flush) begin
         fetch_pc_nxt = target;
         resp_pc_nxt  = target;
         discard_nxt  = outstanding_nxt;
         count_nxt    = '0;
      end else begin
         if (imemRvalid && discard != '0) begin
            discard_nxt = discard - OUT_W'(1);
         end
         if (accept) begin
            resp_pc_nxt = resp_pc + 32'd4;
         end
         count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         fetch_pc    <= fetch_pc_nxt;
         resp_pc     <= resp_pc_nxt;
         outstanding <= outstanding_nxt;
         discard     <= discard_nxt;
         count       <= count_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Buffer storage needs no reset: entries are only read while count covers them
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         buf_pc[wr_ptr]   <= resp_pc;
         buf_inst[wr_ptr] <= imemRdata;
      end
   end

   always_comb begin
      instValid = 1'b0;
      instOut   = NOP;
      pcOut     = resp_pc;
      if (!reset) begin
         pcOut = '0;
      end else if (!empty) begin
         instValid = 1'b1;
         pcOut     = buf_pc[rd_ptr];
         instOut   = buf_inst[rd_ptr];
      end
`ifdef FETCH_BYPASS_EN
      else if (bypass) begin
         instValid = 1'b1;
         instOut   = imemRdata;
      end
`endif
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of the fetch rules.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam int          MAXO     = 2;
   localparam logic [31:0] NOP      = 32'h0000_0033;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0, redirect = 1'b0, trapEn = 1'b0;
   logic [31:0] redirectPc = '0, trapVec = '0;
   logic        imemGnt = 1'b0, imemRvalid = 1'b0;
   logic [31:0] imemRdata = '0;
   logic        imemReq, instValid;
   logic [31:0] imemAddr, pcOut, instOut;

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
      .trapEn(trapEn), .trapVec(trapVec), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemGnt(imemGnt), .imemRvalid(imemRvalid), .imemRdata(imemRdata),
      .pcOut(pcOut), .instOut(instOut), .instValid(instValid));

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
   typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

   entry_t      m_fifo[$];
   pend_t       pend[$];
   logic [31:0] m_fetch, m_resp;
   int          m_out, m_disc;
   int unsigned cyc;
   int          vectors, miscompares;

   int unsigned p_gnt, p_stall, p_rv, max_lat, p_redir, p_trap;
   bit          use_fixed;
   logic [31:0] fix_redir, fix_trap;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a ^ 32'h5A5A_0000) + 32'h0000_1013;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      pend.delete();
      m_fetch = RESET_PC;
      m_resp  = RESET_PC;
      m_out   = 0;
      m_disc  = 0;
   endtask

   task automatic model_outputs(output logic e_req, output logic e_valid,
                                output logic [31:0] e_pc, output logic [31:0] e_inst);
      logic flush;
      flush   = trapEn || redirect;
      e_req   = reset && (m_out + m_fifo.size() < DEPTH) && (m_out < MAXO) && !flush;
      e_valid = 1'b0;
      e_inst  = NOP;
      e_pc    = m_resp;
      if (!reset) begin
         e_pc = '0;
      end else if (m_fifo.size() > 0) begin
         e_valid = 1'b1;
         e_pc    = m_fifo[0].pc;
         e_inst  = m_fifo[0].inst;
      end
`ifdef FETCH_BYPASS_EN
      else if (imemRvalid && !flush && m_disc == 0 && !stall) begin
         e_valid = 1'b1;
         e_inst  = imemRdata;
      end
`endif
   endtask

   task automatic check_outputs();
      logic e_req, e_valid;
      logic [31:0] e_pc, e_inst;
      model_outputs(e_req, e_valid, e_pc, e_inst);
      check("imemReq", 32'(imemReq), 32'(e_req));
      check("imemAddr", imemAddr, m_fetch);
      check("instValid", 32'(instValid), 32'(e_valid));
      check("pcOut", pcOut, e_pc);
      check("instOut", instOut, e_inst);
   endtask

   // One clock: drive at negedge, compare after settling, advance model at posedge
   task automatic cycle_once();
      logic e_req, e_valid, flush, fire, rv, pop_now, byp;
      logic [31:0] e_pc, e_inst, raw;
      @(negedge clk);
      reset      = 1'b1;
      stall      = ($urandom_range(99) < p_stall);
      redirect   = ($urandom_range(999) < p_redir);
      trapEn     = ($urandom_range(999) < p_trap);
      redirectPc = use_fixed ? fix_redir : $urandom;
      trapVec    = use_fixed ? fix_trap : $urandom;
      imemGnt    = ($urandom_range(99) < p_gnt);
      rv         = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(99) < p_rv);
      imemRvalid = rv;
      imemRdata  = rv ? mem_word(pend[0].addr) : $urandom;
      #1;
      check_outputs();
      model_outputs(e_req, e_valid, e_pc, e_inst);
      @(posedge clk);
      flush = trapEn || redirect;
      fire  = e_req && imemGnt;
      if (fire) pend.push_back('{addr: m_fetch, due: cyc + 1 + $urandom_range(max_lat)});
      if (rv) void'(pend.pop_front());
      if (flush) begin
         raw    = trapEn ? trapVec : redirectPc;
         m_out  = m_out - (rv ? 1 : 0);
         m_disc = m_out;
         m_fifo.delete();
         m_fetch = {raw[31:2], 2'b00};
         m_resp  = {raw[31:2], 2'b00};
      end else begin
         pop_now = !stall && (m_fifo.size() > 0);
         byp     = 1'b0;
         if (rv) begin
            m_out--;
            if (m_disc > 0) begin
               m_disc--;
            end else begin
`ifdef FETCH_BYPASS_EN
               byp = (m_fifo.size() == 0) && !stall;
`endif
               if (!byp) m_fifo.push_back('{pc: m_resp, inst: imemRdata});
               m_resp = m_resp + 32'd4;
            end
         end
         if (pop_now) void'(m_fifo.pop_front());
         if (fire) begin
            m_fetch = m_fetch + 32'd4;
            m_out++;
         end
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle_once();
   endtask

   // Asynchronous reset mid-cycle; outputs must return to reset values at once
   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      stall = 1'b0; redirect = 1'b0; trapEn = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(posedge clk);
      cyc += 2;
   endtask

   task automatic knobs(input int unsigned g, input int unsigned s, input int unsigned r,
                        input int unsigned l, input int unsigned rd, input int unsigned tr);
      p_gnt = g; p_stall = s; p_rv = r; max_lat = l; p_redir = rd; p_trap = tr;
   endtask

   task automatic pulse(input logic [31:0] rpc, input logic [31:0] tv, input bit do_trap);
      int unsigned sv_rd, sv_tr;
      sv_rd = p_redir; sv_tr = p_trap;
      use_fixed = 1'b1; fix_redir = rpc; fix_trap = tv;
      p_redir = 1000; p_trap = do_trap ? 1000 : 0;
      run(1);
      use_fixed = 1'b0; p_redir = sv_rd; p_trap = sv_tr;
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0;
      use_fixed = 1'b0; fix_redir = '0; fix_trap = '0;
      model_reset();
      knobs(100, 0, 100, 0, 0, 0);
      do_reset();
      run(40);                                 // streaming, always granted, 1-cycle response
      knobs(100, 100, 100, 0, 0, 0);
      run(6);                                  // hold with buffer full
      knobs(100, 0, 100, 0, 0, 0);
      run(20);
      knobs(100, 0, 100, 2, 0, 0);
      run(10);
      pulse(32'h0000_0100, 32'h0, 1'b0);       // redirect with responses in flight
      run(20);
      pulse(32'h0000_0200, 32'h0000_0080, 1'b1); // trap wins over redirect
      run(20);
      pulse(32'h0000_0103, 32'h0, 1'b0);       // unaligned target
      run(10);
      pulse(32'hFFFF_FFFC, 32'h0, 1'b0);       // address wrap
      run(20);
      pulse(32'h0000_0040, 32'h0, 1'b0);       // back-to-back redirects
      pulse(32'h0000_0300, 32'h0, 1'b0);
      pulse(32'h0000_0500, 32'h0, 1'b0);
      run(20);
      knobs(70, 30, 80, 2, 50, 20);
      run(1500);
      knobs(60, 40, 70, 3, 400, 100);
      run(500);
      do_reset();
      knobs(80, 20, 90, 1, 30, 10);
      run(1500);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule
